// File: rtl/iccm_dump_tx.sv
// iccm_dump_tx: reads a block of 32-bit words from the instruction memory and
// streams them out over a UART transmitter, framed 8N1 and sent little-endian.
// One dump runs from a one-cycle start pulse and ends with a done pulse.
module iccm_dump_tx #(
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [15:0]       clks_per_bit_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] word_count_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic              tx_o,
  output logic              tx_en_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remain_q;
  logic [15:0]       period_q;
  logic [15:0]       cnt_q;
  logic [2:0]        bit_q;
  logic [1:0]        byte_q;
  logic [31:0]       word_q;

  logic              bit_end;
  logic [7:0]        cur_byte;
  logic              tx_bit;

  // Last cycle of the current start/data/stop bit period.
  assign bit_end = (cnt_q == period_q - 16'd1);

  // Select the byte of the captured word currently on the line (LSB byte first).
  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    cur_byte = word_q[7:0];
    case (byte_q)
      2'd1:    cur_byte = word_q[15:8];
      2'd2:    cur_byte = word_q[23:16];
      2'd3:    cur_byte = word_q[31:24];
      default: cur_byte = word_q[7:0];
    endcase
  end

  // Serial line level: low for the start bit, data bit LSB first, high otherwise.
  always_comb begin
    tx_bit = 1'b1;
    case (state_q)
      S_START: tx_bit = 1'b0;
      S_DATA:  tx_bit = cur_byte[bit_q];
      default: tx_bit = 1'b1;
    endcase
  end

  // Outputs decode straight from state, so an asserted reset takes effect at once.
  assign tx_o       = tx_bit;
  assign busy_o     = (state_q != S_IDLE);
  assign tx_en_o    = busy_o;
  assign done_o     = (state_q == S_DONE);
  assign mem_req_o  = (state_q == S_REQ);
  assign mem_addr_o = addr_q;

  // Dump sequencer: fetch a word, shift out its four bytes, advance or finish.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and the update order inside the block is moot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      word_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q   <= base_addr_i;
            remain_q <= word_count_i;
            period_q <= (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;
            state_q  <= (word_count_i == '0) ? S_DONE : S_REQ;
          end
        end
        S_REQ: state_q <= S_WAIT;
        S_WAIT: begin
          if (mem_rvalid_i) begin
            word_q  <= mem_rdata_i;
            byte_q  <= 2'd0;
            cnt_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (byte_q == 2'd3) begin
              remain_q <= remain_q - 1'b1;
              if (remain_q == {{(ADDR_W-1){1'b0}}, 1'b1}) begin
                state_q <= S_DONE;
              end else begin
                addr_q  <= addr_q + 1'b1;
                state_q <= S_REQ;
              end
            end else begin
              byte_q  <= byte_q + 2'd1;
              state_q <= S_START;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
